mem_arbiter_fill: RTL and testbench
===================================

// Module: mem_arbiter_fill
// PURPOSE
//  Shares one multi-cycle unified main memory between the I-cache miss path and the D-cache miss/store path.
//  Arbitrates requests, then sequences a full cache-block fill (issues word addresses, steers returned words
//  into the winning cache) or a single write-through store. Sits between both caches and main memory.
// PARAMETERS
//  WORDS_PER_BLOCK  8   16-bit words per cache block (power of 2); block = 16 bytes
//  ADDR_W           16  byte address width
//  DATA_W           16  memory word width
// PORTS
//  clk        in   1   clock; all state changes on posedge
//  rst        in   1   asynchronous, active-high reset
//  i_req      in   1   I-cache fill request; level, held until i_done
//  i_addr     in   16  I miss byte address; low 4 bits ignored
//  d_req      in   1   D-side request; level, held until d_done
//  d_wr       in   1   1 = single-word write-through store, 0 = block fill
//  d_addr     in   16  D byte address (store: word address, bit0 ignored)
//  d_wdata    in   16  store data
//  mem_rdata  in   16  memory read data
//  mem_rvalid in   1   mem_rdata valid; memory returns reads in issue order, fixed latency (4 cycles)
//  i_grant    out  1   I-side owns memory (held for whole transaction)
//  d_grant    out  1   D-side owns memory
//  fill_data  out  16  returned word (= mem_rdata)
//  fill_word  out  3   word index within block of fill_data
//  i_fill_we  out  1   write fill_data into I-cache data array
//  d_fill_we  out  1   write fill_data into D-cache data array
//  i_done     out  1   one-cycle pulse: I transaction complete
//  d_done     out  1   one-cycle pulse: D transaction complete
//  mem_en     out  1   memory access strobe
//  mem_wr     out  1   memory write (valid with mem_en)
//  mem_addr   out  16  memory byte address
//  mem_wdata  out  16  memory write data
//  busy       out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, counters 0, every output 0, RR pointer = last-served I. Async reset mid-transaction
//   aborts it; no done pulse; mem_rvalid arriving afterwards is ignored (IDLE drops all rvalid).
//  States: IDLE, FILL_I, FILL_D, WRITE. Arbitration only in IDLE; grants registered (visible cycle after).
//   IDLE: d_req&d_wr -> WRITE; d_req&~d_wr -> FILL_D; i_req -> FILL_I; both -> D wins (see CONFIG).
//   WRITE: one cycle; mem_en=1, mem_wr=1, mem_addr={d_addr[15:1],1'b0}, mem_wdata=d_wdata; d_done=1; -> IDLE.
//   FILL_x: issue_cnt 0..WORDS_PER_BLOCK: while issue_cnt<8, mem_en=1, mem_wr=0,
//    mem_addr={blk_addr[15:4],issue_cnt[2:0],1'b0}, issue_cnt++. blk_addr latched at grant.
//    Each mem_rvalid: fill_data=mem_rdata, fill_word=recv_cnt, x_fill_we=1, recv_cnt++.
//    rvalid with recv_cnt==7: x_done=1 same cycle, counters cleared, -> IDLE next edge.
//  Latency: request seen in IDLE cycle 0; issues cycles 1-8; data cycles 5-12; done cycle 12 (13 total).
//  Requester must drop req by the edge ending its done cycle; IDLE never sees a stale request.
//  fill_we/done/mem_en are combinational from state+counters; i_* and d_* outputs never both high.
//  mem_rvalid outside FILL_x, or after 8 words, is ignored. Requests arriving while busy wait (no drop).
//  Counters: issue_cnt, recv_cnt 4 bits; no wrap - saturate at 8, cleared on IDLE entry.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: on simultaneous i_req/d_req in IDLE, grant the side NOT served last;
//   pointer updates on each done pulse; after reset D wins the first tie.
//  Undefined: fixed priority, D always wins ties (I can starve under back-to-back D traffic).
// STRUCTURE
//  Shared package mem_arb_pkg: state encoding (IDLE/FILL_I/FILL_D/WRITE), WORDS_PER_BLOCK,
//   WORD_IDX_W=3, BLOCK_OFFSET_W=4; reused by the cache controllers.
//  One sub-module: arb_select (combinational winner pick from i_req, d_req, d_wr, RR pointer);
//   FSM, counters and address generation stay in mem_arbiter_fill.
// TESTING
//  1 i_req, i_addr=16'h0124, mem returns 16'hA000+idx -> addrs 0x0120..0x012E step 2; i_fill_we x8, fill_word 0-7; i_done cycle 12.
//  2 d_req, d_wr=1, d_addr=16'h3003, d_wdata=16'hBEEF -> one cycle mem_en=mem_wr=1, mem_addr=0x3002, d_done same cycle.
//  3 i_req & d_req(fill) same cycle -> D filled first, then I; no fill_we to wrong side; RR build: next tie goes I.
//  4 d_req raised during FILL_I -> waits; granted the cycle after IDLE re-entry; I fill intact.
//  5 rst pulsed at recv_cnt=3 -> all outputs 0 immediately, no done; late mem_rvalid ignored; new i_req fills cleanly.
//  6 stray mem_rvalid in IDLE -> no fill_we, no state change, busy stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// ---------------------------------------------------------------------------
// mem_arb_pkg
// Shared state encoding and block geometry for the memory arbiter and the
// cache controllers that sit on either side of it.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package mem_arb_pkg;

    localparam int WORDS_PER_BLOCK = 8;
    localparam int WORD_IDX_W      = 3;
    localparam int BLOCK_OFFSET_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FILL_I = 2'd1,
        FILL_D = 2'd2,
        WRITE  = 2'd3
    } arb_state_t;

    function automatic logic is_fill(input arb_state_t s);
        return (s == FILL_I) || (s == FILL_D);
    endfunction

endpackage

`default_nettype wire

// File: rtl/arb_select.sv
// ---------------------------------------------------------------------------
// arb_select
// Combinational winner pick between the I-side and D-side requests; returns
// the state the arbiter should enter from IDLE. Tie policy is set by the
// optional ARB_ROUND_ROBIN_EN macro (undefined: D-side always wins ties).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module arb_select
    import mem_arb_pkg::*;
(
    input  logic       i_req_i,
    input  logic       i_req_d,
    input  logic       i_d_wr,
    input  logic       i_last_i,
    output arb_state_t o_next_state
);

    logic w_pick_d;

    always_comb begin
        w_pick_d = i_req_d;
        if (i_req_d && i_req_i) begin
`ifdef ARB_ROUND_ROBIN_EN
            // Serve the side that did not complete most recently.
            w_pick_d = i_last_i;
`else
            w_pick_d = 1'b1;
`endif
        end

        o_next_state = IDLE;
        if (w_pick_d) begin
            o_next_state = i_d_wr ? WRITE : FILL_D;
        end else if (i_req_i) begin
            o_next_state = FILL_I;
        end
    end

`ifndef ARB_ROUND_ROBIN_EN
    logic w_unused;
    assign w_unused = i_last_i;
`endif

endmodule

`default_nettype wire

// File: rtl/mem_arbiter_fill.sv
// ---------------------------------------------------------------------------
// mem_arbiter_fill
// Shares one fixed-latency main memory between the I-cache fill path and the
// D-cache fill / write-through path. Optional macro: ARB_ROUND_ROBIN_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module mem_arbiter_fill
    import mem_arb_pkg::*;
#(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16,
    parameter int DATA_W          = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               i_req,
    input  logic [ADDR_W-1:0]                  i_addr,
    input  logic                               d_req,
    input  logic                               d_wr,
    input  logic [ADDR_W-1:0]                  d_addr,
    input  logic [DATA_W-1:0]                  d_wdata,
    input  logic [DATA_W-1:0]                  mem_rdata,
    input  logic                               mem_rvalid,
    output logic                               i_grant,
    output logic                               d_grant,
    output logic [DATA_W-1:0]                  fill_data,
    output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
    output logic                               i_fill_we,
    output logic                               d_fill_we,
    output logic                               i_done,
    output logic                               d_done,
    output logic                               mem_en,
    output logic                               mem_wr,
    output logic [ADDR_W-1:0]                  mem_addr,
    output logic [DATA_W-1:0]                  mem_wdata,
    output logic                               busy
);

    localparam int c_idx_w = $clog2(WORDS_PER_BLOCK);
    localparam int c_cnt_w = c_idx_w + 1;
    localparam int c_off_w = c_idx_w + 1;
    localparam logic [c_cnt_w-1:0] c_words = c_cnt_w'(WORDS_PER_BLOCK);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WORDS_PER_BLOCK - 1);

    arb_state_t                 r_state;
    arb_state_t                 w_next_state;
    arb_state_t                 w_arb_state;
    logic [c_cnt_w-1:0]         r_issue_cnt;
    logic [c_cnt_w-1:0]         r_recv_cnt;
    logic [ADDR_W-1:c_off_w]    r_blk_addr;
    logic                       r_last_i;
    logic                       r_i_grant;
    logic                       r_d_grant;
    logic                       w_fill;
    logic                       w_issue;
    logic                       w_accept;
    logic                       w_last;

    arb_select u_arb_select (
        .i_req_i      (i_req),
        .i_req_d      (d_req),
        .i_d_wr       (d_wr),
        .i_last_i     (r_last_i),
        .o_next_state (w_arb_state)
    );

    assign w_fill   = is_fill(r_state);
    assign w_issue  = w_fill && (r_issue_cnt < c_words);
    // Reads beyond the block, or outside a fill, are dropped here.
    assign w_accept = w_fill && mem_rvalid && (r_recv_cnt < c_words);
    assign w_last   = w_accept && (r_recv_cnt == c_last);

    always_comb begin
        w_next_state = r_state;
        mem_en       = 1'b0;
        mem_wr       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        i_fill_we    = 1'b0;
        d_fill_we    = 1'b0;
        i_done       = 1'b0;
        d_done       = 1'b0;

        case (r_state)
            IDLE: begin
                w_next_state = w_arb_state;
            end
            WRITE: begin
                mem_en       = 1'b1;
                mem_wr       = 1'b1;
                mem_addr     = {d_addr[ADDR_W-1:1], 1'b0};
                mem_wdata    = d_wdata;
                d_done       = 1'b1;
                w_next_state = IDLE;
            end
            FILL_I, FILL_D: begin
                if (w_issue) begin
                    mem_en   = 1'b1;
                    mem_addr = {r_blk_addr, r_issue_cnt[c_idx_w-1:0], 1'b0};
                end
                if (w_accept) begin
                    i_fill_we = (r_state == FILL_I);
                    d_fill_we = (r_state == FILL_D);
                end
                if (w_last) begin
                    i_done       = (r_state == FILL_I);
                    d_done       = (r_state == FILL_D);
                    w_next_state = IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_issue_cnt <= '0;
            r_recv_cnt  <= '0;
            r_blk_addr  <= '0;
            r_last_i    <= 1'b1;
            r_i_grant   <= 1'b0;
            r_d_grant   <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_i_grant <= (w_next_state == FILL_I);
            r_d_grant <= (w_next_state == FILL_D) || (w_next_state == WRITE);

            if (w_next_state == IDLE) begin
                r_issue_cnt <= '0;
                r_recv_cnt  <= '0;
            end else begin
                if (w_issue) begin
                    r_issue_cnt <= r_issue_cnt + 1'b1;
                end
                if (w_accept) begin
                    r_recv_cnt <= r_recv_cnt + 1'b1;
                end
            end

            if (r_state == IDLE && w_next_state == FILL_I) begin
                r_blk_addr <= i_addr[ADDR_W-1:c_off_w];
            end else if (r_state == IDLE && w_next_state == FILL_D) begin
                r_blk_addr <= d_addr[ADDR_W-1:c_off_w];
            end

            if (i_done) begin
                r_last_i <= 1'b1;
            end else if (d_done) begin
                r_last_i <= 1'b0;
            end
        end
    end

    assign i_grant   = r_i_grant;
    assign d_grant   = r_d_grant;
    assign busy      = (r_state != IDLE);
    assign fill_data = w_accept ? mem_rdata : '0;
    assign fill_word = r_recv_cnt[c_idx_w-1:0];

    // Block-offset bits of the fill addresses and the store byte bit are don't-care.
    logic w_unused;
    assign w_unused = ^{i_addr[c_off_w-1:0], d_addr[0]};

endmodule

`default_nettype wire

// File: tb/tb_mem_arbiter_fill.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter_fill
// Directed bench for mem_arbiter_fill with a 4-cycle in-order memory model.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_mem_arbiter_fill;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_req = 1'b0;
    logic [15:0] i_addr = '0;
    logic        d_req = 1'b0;
    logic        d_wr = 1'b0;
    logic [15:0] d_addr = '0;
    logic [15:0] d_wdata = '0;
    logic        stray = 1'b0;
    logic [15:0] mem_rdata;
    logic        mem_rvalid;
    logic        i_grant, d_grant, i_fill_we, d_fill_we, i_done, d_done;
    logic        mem_en, mem_wr, busy;
    logic [15:0] fill_data, mem_addr, mem_wdata;
    logic [2:0]  fill_word;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    mem_arbiter_fill #(
        .WORDS_PER_BLOCK (8),
        .ADDR_W          (16),
        .DATA_W          (16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .d_req      (d_req),
        .d_wr       (d_wr),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .mem_rdata  (mem_rdata),
        .mem_rvalid (mem_rvalid),
        .i_grant    (i_grant),
        .d_grant    (d_grant),
        .fill_data  (fill_data),
        .fill_word  (fill_word),
        .i_fill_we  (i_fill_we),
        .d_fill_we  (d_fill_we),
        .i_done     (i_done),
        .d_done     (d_done),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .busy       (busy)
    );

    // Memory model: read issued in cycle n returns in cycle n+4, data = A000 + word index.
    logic [3:0]  pipe_v = 4'b0;
    logic [15:0] pipe_d [4];
    always @(posedge clk) begin
        pipe_v    <= {pipe_v[2:0], mem_en & ~mem_wr};
        pipe_d[0] <= 16'hA000 + {13'b0, mem_addr[3:1]};
        pipe_d[1] <= pipe_d[0];
        pipe_d[2] <= pipe_d[1];
        pipe_d[3] <= pipe_d[2];
    end
    assign mem_rvalid = pipe_v[3] | stray;
    assign mem_rdata  = pipe_v[3] ? pipe_d[3] : 16'h5555;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        n_checks++;
        if ({i_grant, d_grant, i_fill_we, d_fill_we, i_done, d_done, mem_en, mem_wr, busy} !== 9'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 000000000", {i_grant, d_grant, i_fill_we, d_fill_we, i_done, d_done, mem_en, mem_wr, busy});
        end
        n_checks++;
        if ({fill_data, fill_word, mem_addr, mem_wdata} !== 51'b0) begin
            n_fail++;
            $display("FAIL reset_data: got %h want 0", {fill_data, fill_word, mem_addr, mem_wdata});
        end
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_busy: got %b want 0", busy);
        end
    endtask

    task automatic test_stray();
        stray = 1'b1;
        #1;
        n_checks++;
        if ({i_fill_we, d_fill_we, i_done, d_done, busy} !== 5'b0) begin
            n_fail++;
            $display("FAIL stray_rvalid: got %b want 00000", {i_fill_we, d_fill_we, i_done, d_done, busy});
        end
        @(negedge clk);
        stray = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || i_grant !== 1'b0 || d_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL stray_state: got busy=%b grants=%b%b want 0 00", busy, i_grant, d_grant);
        end
    endtask

    task automatic test_tie_fill();
        int i_cyc = -1;
        int d_cyc = -1;
        int i_n = 0;
        int d_n = 0;
        int bad = 0;
        logic [15:0] first_addr = '0;
        logic        first_dg = 1'b0;
        i_addr = 16'h0200; d_addr = 16'h4568; d_wr = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 40 && i_cyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin first_addr = mem_addr; first_dg = d_grant; end
            if ((i_fill_we && !i_grant) || (d_fill_we && !d_grant) || (i_grant && d_grant)) bad++;
            if ((i_fill_we || d_fill_we) && fill_data !== 16'hA000 + {13'b0, fill_word}) bad++;
            if (i_fill_we) i_n++;
            if (d_fill_we) d_n++;
            if (d_done) begin d_cyc = k; d_req = 1'b0; end
            if (i_done) begin i_cyc = k; i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (first_dg !== 1'b1 || first_addr !== 16'h4560) begin
            n_fail++;
            $display("FAIL tie_first: got dgrant=%b addr=%h want 1 4560", first_dg, first_addr);
        end
        n_checks++;
        if (d_cyc != 12 || i_cyc != 25) begin
            n_fail++;
            $display("FAIL tie_done_cycles: got d=%0d i=%0d want d=12 i=25", d_cyc, i_cyc);
        end
        n_checks++;
        if (i_n != 8 || d_n != 8 || bad != 0) begin
            n_fail++;
            $display("FAIL tie_steering: got i_we=%0d d_we=%0d bad=%0d want 8 8 0", i_n, d_n, bad);
        end
    endtask

    task automatic test_write();
        d_addr = 16'h3003; d_wdata = 16'hBEEF; d_wr = 1'b1; d_req = 1'b1;
        #1;
        n_checks++;
        if (mem_en !== 1'b0 || d_grant !== 1'b0) begin
            n_fail++;
            $display("FAIL write_cycle0: got en=%b dgrant=%b want 0 0", mem_en, d_grant);
        end
        @(negedge clk);
        n_checks++;
        if ({mem_en, mem_wr, d_done, d_grant, i_grant} !== 5'b11110 || mem_addr !== 16'h3002 || mem_wdata !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL write_cycle1: got ctl=%b addr=%h wdata=%h want 11110 3002 beef", {mem_en, mem_wr, d_done, d_grant, i_grant}, mem_addr, mem_wdata);
        end
        d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0 || mem_en !== 1'b0 || d_done !== 1'b0) begin
            n_fail++;
            $display("FAIL write_end: got busy=%b en=%b done=%b want 0 0 0", busy, mem_en, d_done);
        end
    endtask

    task automatic test_rr_tie();
        int i_cyc = -1;
        int d_cyc = -1;
        logic first_ig = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        logic exp_ig = 1'b1;
        int   exp_i = 12;
        int   exp_d = 14;
`else
        logic exp_ig = 1'b0;
        int   exp_i = 14;
        int   exp_d = 1;
`endif
        i_addr = 16'h0300; d_addr = 16'h5001; d_wdata = 16'h1234; d_wr = 1'b1;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 1; k <= 40 && (i_cyc < 0 || d_cyc < 0); k++) begin
            @(negedge clk);
            if (k == 1) first_ig = i_grant;
            if (d_done) begin d_cyc = k; d_req = 1'b0; end
            if (i_done) begin i_cyc = k; i_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0; d_wr = 1'b0;
        @(negedge clk);
        n_checks++;
        if (first_ig !== exp_ig) begin
            n_fail++;
            $display("FAIL rr_tie_winner: got igrant=%b want %b", first_ig, exp_ig);
        end
        n_checks++;
        if (i_cyc != exp_i || d_cyc != exp_d) begin
            n_fail++;
            $display("FAIL rr_tie_cycles: got i=%0d d=%0d want i=%0d d=%0d", i_cyc, d_cyc, exp_i, exp_d);
        end
    endtask

    task automatic test_i_fill();
        logic exp_en;
        logic exp_we;
        i_addr = 16'h0124; i_req = 1'b1;
        #1;
        n_checks++;
        if (i_grant !== 1'b0 || mem_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ifill_cycle0: got igrant=%b en=%b want 0 0", i_grant, mem_en);
        end
        for (int k = 1; k <= 13; k++) begin
            @(negedge clk);
            exp_en = (k <= 8);
            exp_we = (k >= 5 && k <= 12);
            n_checks++;
            if (mem_en !== exp_en || (exp_en && (mem_wr !== 1'b0 || mem_addr !== 16'(16'h0120 + 2 * (k - 1))))) begin
                n_fail++;
                $display("FAIL ifill_issue c%0d: got en=%b addr=%h want en=%b addr=%h", k, mem_en, mem_addr, exp_en, 16'(16'h0120 + 2 * (k - 1)));
            end
            n_checks++;
            if (i_fill_we !== exp_we || d_fill_we !== 1'b0 || (exp_we && (fill_word !== 3'(k - 5) || fill_data !== 16'(16'hA000 + k - 5)))) begin
                n_fail++;
                $display("FAIL ifill_data c%0d: got we=%b%b word=%0d data=%h want we=%b0 word=%0d data=%h", k, i_fill_we, d_fill_we, fill_word, fill_data, exp_we, 3'(k - 5), 16'(16'hA000 + k - 5));
            end
            n_checks++;
            if (i_done !== (k == 12) || d_done !== 1'b0 || i_grant !== (k <= 12) || d_grant !== 1'b0 || busy !== (k <= 12)) begin
                n_fail++;
                $display("FAIL ifill_ctrl c%0d: got done=%b%b grant=%b%b busy=%b want done=%b0 grant=%b0 busy=%b", k, i_done, d_done, i_grant, d_grant, busy, k == 12, k <= 12, k <= 12);
            end
            if (k == 12) i_req = 1'b0;
        end
        i_req = 1'b0;
    endtask

    task automatic test_d_wait();
        int i_cyc = -1;
        int d_cyc = -1;
        int g_cyc = -1;
        int i_n = 0;
        int d_n = 0;
        int bad = 0;
        i_addr = 16'h0A40; i_req = 1'b1;
        for (int k = 1; k <= 40 && d_cyc < 0; k++) begin
            @(negedge clk);
            if (k == 3) begin d_req = 1'b1; d_wr = 1'b0; d_addr = 16'h7770; end
            if (d_grant && g_cyc < 0) g_cyc = k;
            if ((i_grant && d_grant) || (d_fill_we && i_cyc < 0)) bad++;
            if (i_fill_we && fill_data !== 16'hA000 + {13'b0, fill_word}) bad++;
            if (i_fill_we) i_n++;
            if (d_fill_we) d_n++;
            if (i_done) begin i_cyc = k; i_req = 1'b0; end
            if (d_done) begin d_cyc = k; d_req = 1'b0; end
        end
        i_req = 1'b0; d_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (i_cyc != 12 || i_n != 8 || bad != 0) begin
            n_fail++;
            $display("FAIL dwait_ifill: got done=%0d we=%0d bad=%0d want 12 8 0", i_cyc, i_n, bad);
        end
        n_checks++;
        if (g_cyc != 14 || d_cyc != 25 || d_n != 8) begin
            n_fail++;
            $display("FAIL dwait_dfill: got grant=%0d done=%0d we=%0d want 14 25 8", g_cyc, d_cyc, d_n);
        end
    endtask

    task automatic test_reset_abort();
        int hit = -1;
        int bad = 0;
        int i_cyc = -1;
        int n = 0;
        logic [15:0] a1 = '0;
        i_addr = 16'h0800; i_req = 1'b1;
        for (int k = 1; k <= 20 && hit < 0; k++) begin
            @(negedge clk);
            if (i_fill_we && fill_word == 3'd3) hit = k;
        end
        rst = 1'b1; i_req = 1'b0;
        #1;
        n_checks++;
        if (hit != 8) begin
            n_fail++;
            $display("FAIL abort_point: got cycle %0d want 8", hit);
        end
        n_checks++;
        if ({i_grant, d_grant, i_fill_we, d_fill_we, i_done, d_done, mem_en, mem_wr, busy} !== 9'b0 || {fill_data, fill_word, mem_addr, mem_wdata} !== 51'b0) begin
            n_fail++;
            $display("FAIL abort_outputs: got ctl=%b data=%h want 0 0", {i_grant, d_grant, i_fill_we, d_fill_we, i_done, d_done, mem_en, mem_wr, busy}, {fill_data, fill_word, mem_addr, mem_wdata});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (i_fill_we || d_fill_we || i_done || d_done || busy) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL abort_late_rvalid: got %0d bad cycles want 0", bad);
        end
        i_addr = 16'h0900; i_req = 1'b1;
        for (int k = 1; k <= 20 && i_cyc < 0; k++) begin
            @(negedge clk);
            if (k == 1) a1 = mem_addr;
            if (i_fill_we) begin
                if (fill_word !== 3'(n) || fill_data !== 16'(16'hA000 + n)) bad++;
                n++;
            end
            if (i_done) begin i_cyc = k; i_req = 1'b0; end
        end
        i_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if (a1 !== 16'h0900 || i_cyc != 12 || n != 8 || bad != 0) begin
            n_fail++;
            $display("FAIL abort_refill: got addr=%h done=%0d we=%0d bad=%0d want 0900 12 8 0", a1, i_cyc, n, bad);
        end
    endtask

    initial begin
        test_reset();
        test_stray();
        test_tie_fill();
        test_write();
        test_rr_tie();
        test_i_fill();
        test_d_wait();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
